// File: rtl/qed_pkg.sv
// Shared types and default sizes for the QED duplicate sequencer.
// Build option: QED_DUP_INTERLEAVE_EN (see qed_dup_sequencer.sv).
package qed_pkg;
  typedef enum logic [1:0] {ORIG = 2'd0, DUP = 2'd1, DONE = 2'd2} qed_state_e;

  localparam int QED_DEPTH = 16;
  localparam int QED_IW    = 32;
endpackage

// File: rtl/qed_sync_fifo.sv
// Replay FIFO with a first-word-fall-through head. Storage is reset so that the
// head reads 0 straight out of reset.
module qed_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [IW-1:0] din,
  output logic [IW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic          last
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][IW-1:0] mem;
  logic [AW:0]              wr_ptr, rd_ptr, occ;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign occ   = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign last  = (occ == (AW+1)'(1));
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/qed_dup_sequencer.sv
// Sequences original/duplicate issue for the QED instruction mux.
// Define QED_DUP_INTERLEAVE_EN to let originals and duplicates interleave.
module qed_dup_sequencer
  import qed_pkg::*;
#(
  parameter int DEPTH = QED_DEPTH,
  parameter int IW    = QED_IW,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          issue_valid,
  input  logic [IW-1:0] qic_instruction,
  input  logic          dup_req,
  output logic          exec_dup,
  output logic [IW-1:0] replay_instr,
  output logic          stall_orig,
  output logic [CW-1:0] orig_count,
  output logic [CW-1:0] dup_count,
  output logic          qed_ready
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  qed_state_e state_q, state_d;
  logic       push, pop, full, empty, last, ready_d;

  qed_sync_fifo #(.DEPTH(DEPTH), .IW(IW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (qic_instruction),
    .head  (replay_instr),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ORIG;
    else        state_q <= state_d;
  end

  // A push in the same cycle as the request counts as having an original.
  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        ORIG: if ((orig_count != '0 || push) && (dup_req || full)) state_d = DUP;
`ifdef QED_DUP_INTERLEAVE_EN
        DUP: if (!dup_req) begin
          if (empty || (pop && last)) state_d = DONE;
          else if (!pop)              state_d = ORIG;
        end
`else
        DUP:  if (pop && last) state_d = DONE;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    exec_dup   = (state_q == DUP);
    stall_orig = full || (state_q == DONE);
    push       = ena && issue_valid && !full  && (state_q == ORIG);
    pop        = ena && issue_valid && !empty && (state_q == DUP);
  end

`ifdef QED_DUP_INTERLEAVE_EN
  assign ready_d = (orig_count == dup_count) && (orig_count != '0);
`else
  // Counts can only match once every duplicate has gone out.
  assign ready_d = (state_q == DONE) && (orig_count == dup_count) && (orig_count != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_count <= '0;
      dup_count  <= '0;
      qed_ready  <= 1'b0;
    end else begin
      if (push && orig_count != CNT_MAX) orig_count <= orig_count + 1'b1;
      if (pop  && dup_count  != CNT_MAX) dup_count  <= dup_count + 1'b1;
      qed_ready <= ready_d;
    end
  end
endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer; expected values are hand-derived.
module tb_qed_dup_sequencer;
  localparam int DEPTH = 16;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, ena, issue_valid, dup_req;
  logic [IW-1:0] qic_instruction;
  logic          exec_dup, stall_orig, qed_ready;
  logic [IW-1:0] replay_instr;
  logic [CW-1:0] orig_count, dup_count;

  int checks   = 0;
  int failures = 0;

  qed_dup_sequencer #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .issue_valid     (issue_valid),
    .qic_instruction (qic_instruction),
    .dup_req         (dup_req),
    .exec_dup        (exec_dup),
    .replay_instr    (replay_instr),
    .stall_orig      (stall_orig),
    .orig_count      (orig_count),
    .dup_count       (dup_count),
    .qed_ready       (qed_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b0; issue_valid = 1'b0; dup_req = 1'b0; qic_instruction = '0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    rst_n = 1'b0; #1;
    chk("rst_exec_dup", exec_dup, 0);
    chk("rst_stall", stall_orig, 0);
    chk("rst_orig_cnt", orig_count, 0);
    chk("rst_dup_cnt", dup_count, 0);
    chk("rst_ready", qed_ready, 0);
    chk("rst_replay", replay_instr, 0);
    rst_n = 1'b1;
    tick();

    // Push on the very first instruction together with dup_req.
    ena = 1'b1; issue_valid = 1'b1; dup_req = 1'b1; qic_instruction = 32'h0000_0044;
    tick();
    issue_valid = 1'b0; dup_req = 1'b0;
    chk("first_push_cnt", orig_count, 1);
    chk("first_push_dup", exec_dup, 1);
    chk("first_push_head", replay_instr, 32'h44);

    // Mid-DUP reset takes effect without a clock edge.
    #2;
    rst_n = 1'b0; #1;
    chk("midrst_exec_dup", exec_dup, 0);
    chk("midrst_orig_cnt", orig_count, 0);
    chk("midrst_dup_cnt", dup_count, 0);
    chk("midrst_ready", qed_ready, 0);
    rst_n = 1'b1;
    tick();

    // ena=0 freezes everything despite issue_valid/dup_req.
    ena = 1'b1; issue_valid = 1'b1; qic_instruction = 32'hABCD_0001;
    tick();
    ena = 1'b0; dup_req = 1'b1; qic_instruction = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) tick();
    chk("ena0_orig_cnt", orig_count, 1);
    chk("ena0_dup_cnt", dup_count, 0);
    chk("ena0_exec_dup", exec_dup, 0);
    chk("ena0_head", replay_instr, 32'hABCD_0001);
    ena = 1'b1; issue_valid = 1'b0;
    tick();
    chk("ena1_to_dup", exec_dup, 1);

`ifndef QED_DUP_INTERLEAVE_EN
    // Strict sequence: A,B,C then three duplicates.
    do_reset();
    ena = 1'b1; issue_valid = 1'b1;
    qic_instruction = 32'hA; tick();
    chk("strict_cnt_a", orig_count, 1);
    chk("strict_orig_phase", exec_dup, 0);
    qic_instruction = 32'hB; tick();
    qic_instruction = 32'hC; dup_req = 1'b1; tick();
    dup_req = 1'b0; qic_instruction = 32'h0;
    chk("strict_orig_cnt", orig_count, 3);
    chk("strict_exec_dup", exec_dup, 1);
    chk("strict_head_a", replay_instr, 32'hA);
    tick();
    chk("strict_head_b", replay_instr, 32'hB);
    chk("strict_dup1", dup_count, 1);
    tick();
    chk("strict_head_c", replay_instr, 32'hC);
    tick();
    chk("strict_dup3", dup_count, 3);
    chk("strict_done_exec", exec_dup, 0);
    chk("strict_done_stall", stall_orig, 1);
    chk("strict_ready_early", qed_ready, 0);
    tick();
    chk("strict_ready", qed_ready, 1);
    chk("strict_done_ignore", orig_count, 3);
    chk("strict_done_ignore_d", dup_count, 3);
`endif

    // Fill the FIFO; the 17th issue is dropped and DUP follows automatically.
    do_reset();
    ena = 1'b1; issue_valid = 1'b1; dup_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      qic_instruction = 32'h100 + i;
      tick();
    end
    qic_instruction = 32'hFFFF;
    chk("full_stall", stall_orig, 1);
    chk("full_cnt", orig_count, 16);
    chk("full_still_orig", exec_dup, 0);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("full_drop_cnt", orig_count, 16);
    chk("full_auto_dup", exec_dup, 1);
    chk("full_head", replay_instr, 32'h100);

`ifdef QED_DUP_INTERLEAVE_EN
    // orig A,B ; dup A ; orig C ; dup B,C
    do_reset();
    ena = 1'b1; issue_valid = 1'b1;
    qic_instruction = 32'hA; tick();
    qic_instruction = 32'hB; dup_req = 1'b1; tick();
    chk("il_dup1_phase", exec_dup, 1);
    chk("il_head_a", replay_instr, 32'hA);
    tick();
    chk("il_dup_a_cnt", dup_count, 1);
    issue_valid = 1'b0; dup_req = 1'b0; tick();
    chk("il_back_orig", exec_dup, 0);
    issue_valid = 1'b1; qic_instruction = 32'hC; dup_req = 1'b1; tick();
    chk("il_orig_c_cnt", orig_count, 3);
    chk("il_head_b", replay_instr, 32'hB);
    dup_req = 1'b0; tick();
    chk("il_head_c", replay_instr, 32'hC);
    tick();
    issue_valid = 1'b0;
    chk("il_dup_cnt", dup_count, 3);
    chk("il_orig_cnt", orig_count, 3);
    chk("il_done", stall_orig, 1);
    tick();
    chk("il_ready", qed_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
